i2s_sample_decimator: RTL and testbench

//  Drains 32-bit PCM samples from the EF_I2S receive FIFO (show-ahead: rdata valid while !empty, rd pops).

---
 rtl/i2s_sample_decimator.sv | 112 +++++++++++
 tb/tb_i2s_sample_decimator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_decimator.sv
// Boxcar decimator draining the EF_I2S receive FIFO.
// Averages 2^dec_log2 samples onto a valid/ready stream.
module i2s_sample_decimator #(
    parameter int DW       = 32,
    parameter int MAX_LOG2 = 7,
    parameter int ACC_W    = DW + MAX_LOG2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    dec_log2,
    input  logic          signed_mode,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [15:0]   out_count
);

    localparam int EXT_W = ACC_W - DW;
    localparam int CNT_W = MAX_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       cfg_dec;
    logic             cfg_signed;

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] shifted;
    logic [CNT_W-1:0] last_cnt;

    always_comb begin
        ext = {{EXT_W{1'b0}}, fifo_rdata};
        if (cfg_signed) begin
            ext = {{EXT_W{fifo_rdata[DW-1]}}, fifo_rdata};
        end
        sum = acc + ext;
        // Arithmetic shift gives floor rounding for negative sums
        if (cfg_signed) begin
            shifted = $signed(sum) >>> cfg_dec;
        end else begin
            shifted = sum >> cfg_dec;
        end
        last_cnt = (CNT_ONE << cfg_dec) - CNT_ONE;
    end

    assign fifo_rd = (state == ACCUM) & en & ~fifo_empty & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            cfg_dec    <= '0;
            cfg_signed <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            out_count  <= '0;
        end else if (!en) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            m_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state      <= ACCUM;
                    cfg_dec    <= dec_log2;
                    cfg_signed <= signed_mode;
                    acc        <= '0;
                    cnt        <= '0;
                end
                ACCUM: begin
                    if (fifo_rd) begin
                        if (cnt == last_cnt) begin
                            state   <= OUT;
                            m_valid <= 1'b1;
                            m_data  <= shifted[DW-1:0];
                            acc     <= '0;
                            cnt     <= '0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        state     <= ACCUM;
                        m_valid   <= 1'b0;
                        out_count <= out_count + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_sample_decimator.sv
// Directed bench for i2s_sample_decimator.
// Small FIFO model feeds the DUT; handshakes are captured in order.
module tb_i2s_sample_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  dec_log2;
    logic        signed_mode;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        fifo_rd;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [15:0] out_count;

    logic [31:0] mem [0:63];
    logic [5:0]  wr_ptr;
    logic [5:0]  rd_ptr;
    int          pops;
    logic [31:0] cap [0:63];
    int          ncap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2s_sample_decimator dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .dec_log2    (dec_log2),
        .signed_mode (signed_mode),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rd     (fifo_rd),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .out_count   (out_count)
    );

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_ptr <= rd_ptr + 6'd1;
            pops   <= pops + 1;
        end
        if (m_valid && m_ready) begin
            cap[ncap[5:0]] <= m_data;
            ncap           <= ncap + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        mem[wr_ptr] = v;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    task automatic wait_cap(input int n, input string tag);
        int k;
        k = 0;
        while (ncap < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, (ncap >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!m_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, m_valid}, 32'd1);
    endtask

    task automatic reconfig(input logic [2:0] d, input logic s);
        en = 1'b0;
        @(negedge clk);
        dec_log2    = d;
        signed_mode = s;
        en          = 1'b1;
    endtask

    initial begin
        int p0;
        int k;
        rst         = 1'b1;
        en          = 1'b0;
        dec_log2    = 3'd0;
        signed_mode = 1'b0;
        m_ready     = 1'b1;
        wr_ptr      = '0;
        rd_ptr      = '0;
        pops        = 0;
        ncap        = 0;
        #12;
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_count", {16'd0, out_count}, 32'd0);
        check("rst_rd", {31'd0, fifo_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // pass-through, unsigned
        en = 1'b1;
        push(32'h5);
        push(32'h7);
        wait_cap(2, "t1_done");
        @(negedge clk);
        check("t1_s0", cap[0], 32'h5);
        check("t1_s1", cap[1], 32'h7);
        check("t1_pops", pops, 2);
        check("t1_count", {16'd0, out_count}, 32'd2);

        // signed average of 4 with floor
        reconfig(3'd2, 1'b1);
        push(32'hFFFF_FFFC);
        push(32'hFFFF_FFFD);
        push(32'hFFFF_FFFE);
        push(32'hFFFF_FFFE);
        wait_cap(3, "t2_done");
        check("t2_avg", cap[2], 32'hFFFF_FFFD);

        reconfig(3'd1, 1'b0);
        push(32'h8000_0000);
        push(32'h8000_0000);
        wait_cap(4, "t3u_done");
        check("t3_unsigned", cap[3], 32'h8000_0000);
        reconfig(3'd1, 1'b1);
        push(32'h8000_0000);
        push(32'h8000_0000);
        wait_cap(5, "t3s_done");
        check("t3_signed", cap[4], 32'h8000_0000);

        // backpressure
        reconfig(3'd0, 1'b0);
        m_ready = 1'b0;
        push(32'h1234);
        push(32'h9999);
        wait_valid("t4_valid");
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_v", {31'd0, m_valid}, 32'd1);
            check("t4_hold_d", m_data, 32'h1234);
            check("t4_hold_rd", {31'd0, fifo_rd}, 32'd0);
        end
        check("t4_pops", pops, p0);
        check("t4_level", {26'd0, wr_ptr - rd_ptr}, 32'd1);
        m_ready = 1'b1;
        wait_cap(7, "t4_done");
        check("t4_s0", cap[5], 32'h1234);
        check("t4_s1", cap[6], 32'h9999);

        // en drop mid-accumulation discards partial sum
        reconfig(3'd2, 1'b0);
        p0 = pops;
        push(32'd100);
        push(32'd200);
        k = 0;
        while (pops < p0 + 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t5_two_pops", pops, p0 + 2);
        en = 1'b0;
        #1;
        check("t5_rd_gated", {31'd0, fifo_rd}, 32'd0);
        @(negedge clk);
        check("t5_valid", {31'd0, m_valid}, 32'd0);
        en = 1'b1;
        push(32'd4);
        push(32'd4);
        push(32'd8);
        push(32'd8);
        wait_cap(8, "t5_done");
        check("t5_avg", cap[7], 32'd6);
        @(negedge clk);
        check("t5_count", {16'd0, out_count}, 32'd8);

        // async reset while holding an output
        m_ready = 1'b0;
        push(32'd1);
        push(32'd1);
        push(32'd1);
        push(32'd1);
        wait_valid("t6_valid");
        check("t6_data", m_data, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_valid_rst", {31'd0, m_valid}, 32'd0);
        check("t6_rd_rst", {31'd0, fifo_rd}, 32'd0);
        check("t6_count_rst", {16'd0, out_count}, 32'd0);
        check("t6_data_rst", m_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
